// File: rtl/vp_pattern_gen_if.sv
// vp_pattern_gen_if: video stream from the pattern generator plus the exported square position
// master drives de/h_sync/v_sync/pixel and obj_x/obj_y; slave observes them
interface vp_pattern_gen_if;
  logic        de_out;
  logic        h_sync_out;
  logic        v_sync_out;
  logic [23:0] pixel_out;
  logic [10:0] obj_x;
  logic [10:0] obj_y;
  modport master (output de_out, h_sync_out, v_sync_out, pixel_out, obj_x, obj_y);
  modport slave  (input  de_out, h_sync_out, v_sync_out, pixel_out, obj_x, obj_y);
endinterface

// File: rtl/vp_pattern_gen.sv
// vp_pattern_gen: synthetic raster source with bars, ramp, solid and a bouncing square pattern
// clk/rst: pixel clock and synchronous active-high reset; en low freezes the raster
// mode: 0 square on black, 1 colour bars, 2 grey ramp, 3 solid OBJ_COLOR (applied per frame)
// vid: registered de/h_sync/v_sync/pixel and the square position of the frame being output
module vp_pattern_gen #(
  parameter int          IMG_W     = 64,
  parameter int          IMG_H     = 64,
  parameter int          H_FP      = 4,
  parameter int          H_SYNC    = 8,
  parameter int          H_BP      = 4,
  parameter int          V_FP      = 2,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 2,
  parameter int          OBJ_SIZE  = 8,
  parameter int          OBJ_X0    = 10,
  parameter int          OBJ_Y0    = 20,
  parameter int          STEP      = 1,
  parameter logic [23:0] OBJ_COLOR = 24'hFF0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  vp_pattern_gen_if.master vid
);
  localparam logic [10:0] H_TOT = 11'(IMG_W + H_FP + H_SYNC + H_BP);
  localparam logic [10:0] V_TOT = 11'(IMG_H + V_FP + V_SYNC + V_BP);
  localparam logic [10:0] HS0   = 11'(IMG_W + H_FP);
  localparam logic [10:0] HS1   = 11'(IMG_W + H_FP + H_SYNC);
  localparam logic [10:0] VS0   = 11'(IMG_H + V_FP);
  localparam logic [10:0] VS1   = 11'(IMG_H + V_FP + V_SYNC);
  localparam logic [10:0] W     = 11'(IMG_W);
  localparam logic [10:0] H     = 11'(IMG_H);
  localparam logic [10:0] SZ    = 11'(OBJ_SIZE);
  localparam logic [10:0] XMAX  = 11'(IMG_W - OBJ_SIZE);
  localparam logic [10:0] YMAX  = 11'(IMG_H - OBJ_SIZE);
  localparam logic [10:0] ST    = 11'(STEP);
  localparam logic [10:0] BW    = 11'(IMG_W / 8);
  localparam logic [10:0] X0    = 11'(OBJ_X0);
  localparam logic [10:0] Y0    = 11'(OBJ_Y0);
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic        dx_q, dx_d, dy_q, dy_d;
  logic [1:0]  mode_q;
  logic        de_q, hs_q, vs_q;
  logic [23:0] pix_q, pix_d;
  logic [10:0] obj_x_q, obj_y_q;
  logic        h_last, frame_end, active, hs_d, vs_d, in_obj;
  logic [2:0]  bar_i;
  logic [7:0]  gray;
  // returns {dir, pos}; dir 1 means moving towards 0, clamping at either edge reverses
  function automatic logic [11:0] bounce(input logic [10:0] p, input logic d, input logic [10:0] m);
    return d ? (p <= ST ? 12'd0 : {1'b1, p - ST}) : (p + ST >= m ? {1'b1, m} : {1'b0, p + ST});
  endfunction
  always_comb begin
    h_last    = hcnt_q == H_TOT - 11'd1;
    frame_end = h_last && vcnt_q == V_TOT - 11'd1;
    hcnt_d    = h_last ? '0 : hcnt_q + 11'd1;
    vcnt_d    = frame_end ? '0 : vcnt_q + {10'd0, h_last};
    active    = hcnt_q < W && vcnt_q < H;
    hs_d      = hcnt_q >= HS0 && hcnt_q < HS1;
    vs_d      = vcnt_q >= VS0 && vcnt_q < VS1;
    in_obj    = hcnt_q >= x_q && hcnt_q < x_q + SZ && vcnt_q >= y_q && vcnt_q < y_q + SZ;
    bar_i     = 3'(hcnt_q / BW);
    gray      = 8'({hcnt_q, 8'd0} / 19'(IMG_W));
    pix_d     = !active ? '0 :
                mode_q == 2'd0 ? (in_obj ? OBJ_COLOR : '0) :
                mode_q == 2'd1 ? BARS[bar_i] :
                mode_q == 2'd2 ? {3{gray}} : OBJ_COLOR;
    {dx_d, x_d} = bounce(x_q, dx_q, XMAX);
    {dy_d, y_d} = bounce(y_q, dy_q, YMAX);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      x_q     <= X0;
      y_q     <= Y0;
      dx_q    <= 1'b0;
      dy_q    <= 1'b0;
      mode_q  <= mode;
      de_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      pix_q   <= '0;
      obj_x_q <= X0;
      obj_y_q <= Y0;
    end else if (en) begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      de_q    <= active;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      pix_q   <= pix_d;
      // position lags with the pixels, so it switches together with pixel (0,0)
      obj_x_q <= x_q;
      obj_y_q <= y_q;
      if (frame_end) begin
        mode_q <= mode;
        x_q    <= x_d;
        y_q    <= y_d;
        dx_q   <= dx_d;
        dy_q   <= dy_d;
      end
    end else begin
      de_q  <= 1'b0;
      pix_q <= '0;
    end
  end
  assign vid.de_out     = de_q;
  assign vid.h_sync_out = hs_q;
  assign vid.v_sync_out = vs_q;
  assign vid.pixel_out  = pix_q;
  assign vid.obj_x      = obj_x_q;
  assign vid.obj_y      = obj_y_q;
endmodule

// File: tb/tb_vp_pattern_gen.sv
// tb_vp_pattern_gen: directed checks of raster timing, patterns, motion, enable and reset
// The DUT runs with IMG_H=24, OBJ_Y0=4, STEP=4 so many frames and both bounce edges fit a short run:
// 80x30 raster = 2400 clocks/frame, 1536 de clocks, 30 h_sync pulses, 160 v_sync clocks.
module tb_vp_pattern_gen;
  localparam int HT = 80;
  localparam int FRAME = 2400;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [1:0] mode = 2'd0;
  int errors = 0;
  int checks = 0;
  int de_n, red_n, red_in, hs_pulses, hs_high, vs_high, vs_runs, first_de, de_bad, pix_bad, ox, oy;
  logic [23:0] line0 [64];
  int exp_x [14] = '{10, 14, 18, 22, 26, 30, 34, 38, 42, 46, 50, 54, 56, 52};
  int exp_y [14] = '{4, 8, 12, 16, 12, 8, 4, 0, 4, 8, 12, 16, 12, 8};
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  vp_pattern_gen_if vid();
  vp_pattern_gen #(.IMG_H(24), .OBJ_Y0(4), .STEP(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .vid(vid)
  );
  always #5 clk = ~clk;
  // captures one frame starting while the DUT counters sit at (0,0); optional mode change at a line
  task automatic capture_frame(input int chg_line, input logic [1:0] chg_mode);
    logic hs_prev, vs_prev;
    int px, py;
    hs_prev = vid.h_sync_out;
    vs_prev = vid.v_sync_out;
    de_n = 0; red_n = 0; red_in = 0; hs_pulses = 0; hs_high = 0; vs_high = 0; vs_runs = 0;
    first_de = -1; de_bad = 0; pix_bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (chg_line >= 0 && i == chg_line * HT) mode = chg_mode;
      @(negedge clk);
      px = i % HT;
      py = i / HT;
      if (i == 0) begin
        ox = int'(vid.obj_x);
        oy = int'(vid.obj_y);
      end
      if (vid.de_out) begin
        de_n++;
        if (first_de < 0) first_de = i + 1;
        if (px >= 64 || py >= 24) de_bad++;
        if (vid.pixel_out == 24'hFF0000) begin
          red_n++;
          if (px >= ox && px < ox + 8 && py >= oy && py < oy + 8) red_in++;
        end
      end else if (vid.pixel_out != 24'd0) pix_bad++;
      if (py == 0 && px < 64) line0[px] = vid.pixel_out;
      if (vid.h_sync_out) hs_high++;
      if (vid.h_sync_out && !hs_prev) hs_pulses++;
      if (vid.v_sync_out) vs_high++;
      if (vid.v_sync_out && !vs_prev) vs_runs++;
      hs_prev = vid.h_sync_out;
      vs_prev = vid.v_sync_out;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0;
    mode = 2'd0;
    repeat (3) @(negedge clk);
    checks++; if (vid.de_out !== 1'b0) begin errors++; $display("FAIL reset_de: got %b want 0", vid.de_out); end
    checks++; if (vid.h_sync_out !== 1'b0 || vid.v_sync_out !== 1'b0) begin errors++; $display("FAIL reset_sync: got %b%b want 00", vid.h_sync_out, vid.v_sync_out); end
    checks++; if (vid.pixel_out !== 24'd0) begin errors++; $display("FAIL reset_pixel: got %h want 000000", vid.pixel_out); end
    checks++; if (vid.obj_x !== 11'd10 || vid.obj_y !== 11'd4) begin errors++; $display("FAIL reset_obj: got %0d,%0d want 10,4", vid.obj_x, vid.obj_y); end
  endtask
  task automatic test_frame();
    en = 1'b1;
    rst = 1'b0;
    capture_frame(-1, 2'd0);
    checks++; if (de_n !== 1536) begin errors++; $display("FAIL frame_de: got %0d want 1536", de_n); end
    checks++; if (first_de !== 1) begin errors++; $display("FAIL frame_first_de: got %0d want 1", first_de); end
    checks++; if (hs_pulses !== 30 || hs_high !== 240) begin errors++; $display("FAIL frame_hsync: got %0d pulses %0d clocks want 30 240", hs_pulses, hs_high); end
    checks++; if (vs_runs !== 1 || vs_high !== 160) begin errors++; $display("FAIL frame_vsync: got %0d runs %0d clocks want 1 160", vs_runs, vs_high); end
    checks++; if (de_bad !== 0 || pix_bad !== 0) begin errors++; $display("FAIL frame_blank: got de_bad=%0d pix_bad=%0d want 0 0", de_bad, pix_bad); end
    checks++; if (ox !== 10 || oy !== 4) begin errors++; $display("FAIL frame_obj: got %0d,%0d want 10,4", ox, oy); end
    checks++; if (red_n !== 64 || red_in !== 64) begin errors++; $display("FAIL frame_square: got %0d red %0d inside want 64 64", red_n, red_in); end
  endtask
  task automatic test_motion();
    for (int k = 1; k < 14; k++) begin
      capture_frame(-1, 2'd0);
      checks++; if (ox !== exp_x[k]) begin errors++; $display("FAIL motion_x[%0d]: got %0d want %0d", k, ox, exp_x[k]); end
      checks++; if (oy !== exp_y[k]) begin errors++; $display("FAIL motion_y[%0d]: got %0d want %0d", k, oy, exp_y[k]); end
      checks++; if (red_n !== 64 || red_in !== 64) begin errors++; $display("FAIL motion_square[%0d]: got %0d red %0d inside want 64 64", k, red_n, red_in); end
    end
  endtask
  task automatic test_bars();
    capture_frame(0, 2'd1);
    checks++; if (red_n !== 64) begin errors++; $display("FAIL bars_prev_frame: got %0d red want 64", red_n); end
    capture_frame(0, 2'd2);
    for (int p = 0; p < 64; p++) begin
      checks++; if (line0[p] !== bars[p / 8]) begin errors++; $display("FAIL bars_px[%0d]: got %h want %h", p, line0[p], bars[p / 8]); end
    end
  endtask
  task automatic test_ramp();
    capture_frame(0, 2'd0);
    checks++; if (line0[0] !== 24'h000000) begin errors++; $display("FAIL ramp_px0: got %h want 000000", line0[0]); end
    checks++; if (line0[1] !== 24'h040404) begin errors++; $display("FAIL ramp_px1: got %h want 040404", line0[1]); end
    checks++; if (line0[32] !== 24'h808080) begin errors++; $display("FAIL ramp_px32: got %h want 808080", line0[32]); end
    checks++; if (line0[63] !== 24'hFCFCFC) begin errors++; $display("FAIL ramp_px63: got %h want FCFCFC", line0[63]); end
  endtask
  task automatic test_mode_change();
    capture_frame(15, 2'd3);
    checks++; if (red_n !== 64 || red_in !== 64) begin errors++; $display("FAIL midframe_mode: got %0d red %0d inside want 64 64", red_n, red_in); end
    capture_frame(-1, 2'd3);
    checks++; if (red_n !== 1536 || de_n !== 1536) begin errors++; $display("FAIL solid_frame: got %0d red %0d de want 1536 1536", red_n, de_n); end
  endtask
  task automatic test_enable();
    int frz_bad, sync_bad, seg_de, px;
    logic hs_hold, vs_hold, hv_high;
    frz_bad = 0; sync_bad = 0; seg_de = 0; de_n = 0; hv_high = 1'b0;
    mode = 2'd0;
    for (int idx = 0; idx < FRAME; idx++) begin
      if (idx == 5 * HT + 20 || idx == 26 * HT + 70) begin
        hs_hold = vid.h_sync_out;
        vs_hold = vid.v_sync_out;
        if (idx == 26 * HT + 70) hv_high = hs_hold && vs_hold;
        en = 1'b0;
        repeat (idx == 5 * HT + 20 ? 100 : 20) begin
          @(negedge clk);
          if (vid.de_out !== 1'b0 || vid.pixel_out !== 24'd0) frz_bad++;
          if (vid.h_sync_out !== hs_hold || vid.v_sync_out !== vs_hold) sync_bad++;
        end
        en = 1'b1;
      end
      @(negedge clk);
      px = idx % HT;
      if (vid.de_out) de_n++;
      if (idx / HT == 5 && px >= 20 && px < 64 && vid.de_out) seg_de++;
    end
    checks++; if (frz_bad !== 0) begin errors++; $display("FAIL en_blank: got %0d active samples want 0", frz_bad); end
    checks++; if (sync_bad !== 0) begin errors++; $display("FAIL en_sync_hold: got %0d changes want 0", sync_bad); end
    checks++; if (hv_high !== 1'b1) begin errors++; $display("FAIL en_sync_level: got %b want 1", hv_high); end
    checks++; if (seg_de !== 44) begin errors++; $display("FAIL en_resume_line: got %0d want 44", seg_de); end
    checks++; if (de_n !== 1536) begin errors++; $display("FAIL en_frame_de: got %0d want 1536", de_n); end
  endtask
  task automatic test_reset_mid();
    mode = 2'd0;
    repeat (12 * HT + 70) @(negedge clk);
    checks++; if (vid.h_sync_out !== 1'b1) begin errors++; $display("FAIL pre_rst_hsync: got %b want 1", vid.h_sync_out); end
    checks++; if (vid.obj_x !== 11'd24 || vid.obj_y !== 11'd12) begin errors++; $display("FAIL pre_rst_obj: got %0d,%0d want 24,12", vid.obj_x, vid.obj_y); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (vid.h_sync_out !== 1'b0 || vid.v_sync_out !== 1'b0 || vid.de_out !== 1'b0 || vid.pixel_out !== 24'd0) begin errors++; $display("FAIL rst_outputs: got hs=%b vs=%b de=%b px=%h want 0 0 0 000000", vid.h_sync_out, vid.v_sync_out, vid.de_out, vid.pixel_out); end
    checks++; if (vid.obj_x !== 11'd10 || vid.obj_y !== 11'd4) begin errors++; $display("FAIL rst_obj: got %0d,%0d want 10,4", vid.obj_x, vid.obj_y); end
    rst = 1'b0;
    capture_frame(-1, 2'd0);
    checks++; if (de_n !== 1536 || first_de !== 1) begin errors++; $display("FAIL post_rst_de: got %0d first %0d want 1536 1", de_n, first_de); end
    checks++; if (hs_pulses !== 30 || vs_runs !== 1) begin errors++; $display("FAIL post_rst_sync: got %0d %0d want 30 1", hs_pulses, vs_runs); end
    checks++; if (ox !== 10 || oy !== 4 || red_in !== 64) begin errors++; $display("FAIL post_rst_obj: got %0d,%0d inside %0d want 10,4 64", ox, oy, red_in); end
  endtask
  initial begin
    test_reset();
    test_frame();
    test_motion();
    test_bars();
    test_ramp();
    test_mode_change();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vp_pattern_gen.md
# vp_pattern_gen

Synthetic video source that drives the vision pipeline's input stream (`de`/`h_sync`/`v_sync`/`pixel`) in place of the camera/HDMI receiver for bring-up and closed-loop verification. It generates raster timing for a small frame and one of four test patterns, including a bouncing square whose exact position is exported, so a bench can score the downstream centroid and bounding-box results frame by frame.

## Interface
- IMG_W, 64, active pixels per line; multiple of 8
- IMG_H, 64, active lines per frame
- H_FP, 4 / H_SYNC, 8 / H_BP, 4: horizontal porch and sync lengths in clocks
- V_FP, 2 / V_SYNC, 2 / V_BP, 2: vertical porch and sync lengths in lines
- OBJ_SIZE, 8, square side in pixels
- OBJ_X0, 10 / OBJ_Y0, 20: square position after reset
- STEP, 1, pixels moved per frame on each axis
- OBJ_COLOR, 24'hFF0000, square colour as {R,G,B}
- clk  in  1  pixel clock; single clock domain
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable; low freezes the raster
- mode  in  2  pattern select: 0 square on black, 1 colour bars, 2 grey ramp, 3 solid OBJ_COLOR
- de_out  out  1  active-video flag
- h_sync_out  out  1  horizontal sync, active-high
- v_sync_out  out  1  vertical sync, active-high
- pixel_out  out  24  {R[23:16],G[15:8],B[7:0]}
- obj_x  out  11  left edge of the square in the frame being output
- obj_y  out  11  top edge of the square in the frame being output

## Operation
- Counters: hcnt 0..H_TOT-1 with H_TOT = IMG_W+H_FP+H_SYNC+H_BP (80 with defaults). vcnt 0..V_TOT-1 with V_TOT = IMG_H+V_FP+V_SYNC+V_BP (70 with defaults). Both are 11 bits. vcnt advances when hcnt wraps. Both wrap to 0 at the end of the frame.
- Active region: hcnt<IMG_W and vcnt<IMG_H.
- h_sync: asserted when IMG_W+H_FP ≤ hcnt < IMG_W+H_FP+H_SYNC (68..75 with defaults).
- v_sync: asserted for every hcnt of lines with IMG_H+V_FP ≤ vcnt < IMG_H+V_FP+V_SYNC (66..67 with defaults).
- Mode 0: OBJ_COLOR inside the square (x ≤ hcnt < x+OBJ_SIZE and y ≤ vcnt < y+OBJ_SIZE); 0 elsewhere.
- Mode 1: 8 bars, each IMG_W/8 wide, with index = hcnt/(IMG_W/8). Order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Mode 2: R=G=B=(hcnt·256/IMG_W)[7:0], which is hcnt·4 with defaults.
- Mode 3: OBJ_COLOR over the whole active area.
- pixel_out is 0 whenever de_out is 0.
- Frame boundary: the clock edge at which (hcnt,vcnt) = (H_TOT-1, V_TOT-1) and en=1.
  - mode is sampled into mode_q. A mode change mid-frame takes effect only from the next frame.
  - The square moves. XMAX = IMG_W-OBJ_SIZE. With dir_x=+: if x+STEP ≥ XMAX then x←XMAX and dir_x←−, else x←x+STEP. With dir_x=−: if x ≤ STEP then x←0 and dir_x←+, else x←x−STEP. The y axis follows the same rule with IMG_H.
- Square motion occurs in every mode, so switching back to mode 0 shows the current position.
- en=0:
  - counters, position, direction and mode_q hold;
  - de_out=0, pixel_out=0;
  - h_sync_out and v_sync_out hold their last values;
  - resuming continues from the held counters.

## Timing
- All outputs are registered. The outputs on cycle n+1 reflect the counters on cycle n, giving a 1-clock latency.
- obj_x/obj_y carry the same lag and change on the same edge that outputs the frame's pixel (0,0).
- Reset values:
  - counters 0;
  - x=OBJ_X0, y=OBJ_Y0, dir_x=dir_y=+;
  - mode_q=mode;
  - de_out=h_sync_out=v_sync_out=0, pixel_out=0;
  - obj_x=OBJ_X0, obj_y=OBJ_Y0.
- First frame after reset: the first cycle with rst=0 and en=1 has counters at (0,0). de_out rises on the following edge.
- Reset mid-frame: the next frame restarts from (0,0) with the reset position. No partial line or sync pulse is completed.
- Defaults: 5600 clocks per frame, 64 de-high clocks per line, 8-clock h_sync pulse, v_sync high for 160 consecutive clocks.

## Test plan
- Reset, then en=1 and mode=0 for 1 frame -> exactly 4096 de-high cycles, 70 h_sync pulses of 8 clocks each, one v_sync run of 160 clocks; first de_out on the 2nd cycle after reset release.
- Mode 0 with defaults, capture frames 0..48 -> frame k has x=10+k for k≤46, x=55 at k=47, x=54 at k=48; y=56 at k=36, y=55 at k=37. Exactly 64 pixels equal FF0000 per frame, at the reported obj_x/obj_y.
- Mode 1 -> line pixels 0..7 = FFFFFF, 8..15 = FFFF00, …, 56..63 = 000000. Mode 2 -> pixel 63 = FCFCFC.
- mode changes 0->3 at line 30 -> the rest of that frame stays mode 0. The next frame is 4096 pixels of FF0000.
- en low for 100 cycles mid-line at hcnt=20 -> de_out and pixel_out are 0 and syncs are frozen. After resume, the line finishes with hcnt 20..63 active and the frame still totals 4096 de cycles.
- rst pulsed at vcnt=40 -> all outputs take reset values the next cycle. The following frame is complete with obj_x=10, obj_y=20.
